// File: rtl/imm_pkg.sv
// imm_pkg: immediate format codes and RV opcodes shared by imm_gen_pipe and its extender.
package imm_pkg;
   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100,
      IMM_Z = 3'b101
   } imm_fmt_e;
   localparam logic [2:0] IMM_ILL   = 3'b110;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

// File: rtl/imm_gen_pipe_ext.sv
// imm_gen_pipe_ext: combinational instr/format to XLEN immediate plus illegal flag.
// IMM_AUTODECODE_EN derives the format from the opcode and ignores fmt.
module imm_gen_pipe_ext
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [2:0]      fmt,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);
   logic [2:0] f;
   logic [6:0] op;
   assign op = instr[6:0];
`ifdef IMM_AUTODECODE_EN
   logic unused_fmt;
   assign unused_fmt = ^fmt;
   assign f = (op == OP_IMM || op == OP_LOAD || op == OP_JALR) ? IMM_I :
              op == OP_STORE                    ? IMM_S :
              op == OP_BRANCH                   ? IMM_B :
              (op == OP_LUI || op == OP_AUIPC)  ? IMM_U :
              op == OP_JAL                      ? IMM_J :
              op == OP_SYSTEM                   ? (instr[14] ? IMM_Z : IMM_I) :
                                                  IMM_ILL;
`else
   logic unused_op;
   assign unused_op = ^op;
   assign f = fmt;
`endif
   assign illegal = f[2] & f[1];
   // Sized signed casts sign-extend to XLEN, so one expression covers both widths
   always_comb
      imm = f == IMM_I ? XLEN'($signed(instr[31:20])) :
            f == IMM_S ? XLEN'($signed({instr[31:25], instr[11:7]})) :
            f == IMM_B ? XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})) :
            f == IMM_U ? XLEN'($signed({instr[31:12], 12'b0})) :
            f == IMM_J ? XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})) :
            f == IMM_Z ? XLEN'(instr[19:15]) :
                         '0;
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator behind a 2-entry valid/ready skid FIFO with tag and illegal flag.
// Build option IMM_AUTODECODE_EN is handled inside imm_gen_pipe_ext.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_fmt,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);
   logic [1:0]       count;
   logic             push, pop, load_h, shift, load_t;
   logic [XLEN-1:0]  n_imm, t_imm;
   logic             n_ill, t_ill;
   logic [TAG_W-1:0] t_tag;
   imm_gen_pipe_ext #(.XLEN(XLEN)) ext (
      .instr(in_instr),
      .fmt(in_fmt),
      .imm(n_imm),
      .illegal(n_ill)
   );
   assign in_ready  = rst_n & (count != 2'd2);
   assign out_valid = count != 2'd0;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   // Head takes the new entry when empty or when its sole occupant leaves this cycle
   assign load_h    = push & (count == 2'd0 | pop);
   assign shift     = pop & (count == 2'd2);
   assign load_t    = push & (count == 2'd1) & !pop;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         out_imm     <= '0;
         out_tag     <= '0;
         out_illegal <= 1'b0;
         t_imm       <= '0;
         t_tag       <= '0;
         t_ill       <= 1'b0;
      end else begin
         count <= count + {1'b0, push} - {1'b0, pop};
         if (load_h) begin
            out_imm     <= n_imm;
            out_tag     <= in_tag;
            out_illegal <= n_ill;
         end else if (shift) begin
            out_imm     <= t_imm;
            out_tag     <= t_tag;
            out_illegal <= t_ill;
         end
         if (load_t) begin
            t_imm <= n_imm;
            t_tag <= in_tag;
            t_ill <= n_ill;
         end
      end
   end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table-driven check of imm_gen_pipe at XLEN 32 and 64 sharing one stimulus stream.
module tb_imm_gen_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [2:0]  in_fmt;
   logic [3:0]  in_tag;
   logic        out_ready;
   logic        ir32, ov32, il32, ir64, ov64, il64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   logic [3:0]  tag32, tag64;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
      .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag),
      .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
      .out_tag(tag32), .out_illegal(il32)
   );
   imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64),
      .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag),
      .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
      .out_tag(tag64), .out_illegal(il64)
   );

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  fmt;
      logic [63:0] exp;
      logic        ill;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [63:0] e, input logic [3:0] t, input logic il);
      chk({nm, " valid32"}, 64'(ov32), 64'd1);
      chk({nm, " valid64"}, 64'(ov64), 64'd1);
      chk({nm, " imm32"}, {32'b0, imm32}, {32'b0, e[31:0]});
      chk({nm, " imm64"}, imm64, e);
      chk({nm, " tag32"}, 64'(tag32), 64'(t));
      chk({nm, " tag64"}, 64'(tag64), 64'(t));
      chk({nm, " ill32"}, 64'(il32), 64'(il));
      chk({nm, " ill64"}, 64'(il64), 64'(il));
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " valid32"}, 64'(ov32), 64'd0);
      chk({nm, " valid64"}, 64'(ov64), 64'd0);
      chk({nm, " imm32"}, {32'b0, imm32}, 64'd0);
      chk({nm, " imm64"}, imm64, 64'd0);
      chk({nm, " tag"}, 64'({tag32, tag64}), 64'd0);
      chk({nm, " ill"}, 64'({il32, il64}), 64'd0);
   endtask

   task automatic chk_ready(input string nm, input logic r);
      chk({nm, " ready32"}, 64'(ir32), 64'(r));
      chk({nm, " ready64"}, 64'(ir64), 64'(r));
   endtask

   task automatic drv(input logic [31:0] ins, input logic [2:0] f, input logic [3:0] t);
      in_valid = 1'b1;
      in_instr = ins;
      in_fmt   = f;
      in_tag   = t;
   endtask

   initial begin
      // Every vector decodes identically with and without opcode autodecode
      tbl[0]  = '{32'hFFF00093, 3'd0, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
      tbl[1]  = '{32'h7FF00013, 3'd0, 64'h00000000_000007FF, 1'b0};
      tbl[2]  = '{32'hFE112E23, 3'd1, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
      tbl[3]  = '{32'h00000FA3, 3'd1, 64'h00000000_0000001F, 1'b0};
      tbl[4]  = '{32'hFE000EE3, 3'd2, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
      tbl[5]  = '{32'h00000463, 3'd2, 64'h00000000_00000008, 1'b0};
      tbl[6]  = '{32'h800000B7, 3'd3, 64'hFFFFFFFF_80000000, 1'b0};
      tbl[7]  = '{32'h12345037, 3'd3, 64'h00000000_12345000, 1'b0};
      tbl[8]  = '{32'h0080006F, 3'd4, 64'h00000000_00000008, 1'b0};
      tbl[9]  = '{32'hFFFFF06F, 3'd4, 64'hFFFFFFFF_FFFFFFFE, 1'b0};
      tbl[10] = '{32'h0002D073, 3'd5, 64'h00000000_00000005, 1'b0};
      tbl[11] = '{32'hFFFFFFF3, 3'd5, 64'h00000000_0000001F, 1'b0};
      tbl[12] = '{32'hFFFFFFFF, 3'd6, 64'h0, 1'b1};
      tbl[13] = '{32'h0000007F, 3'd7, 64'h0, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_fmt = '0; in_tag = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      chk_ready("reset", 1'b0);
      rst_n = 1'b1;
      #1 chk_ready("release", 1'b1);

      foreach (tbl[i]) begin
         @(negedge clk);
         drv(tbl[i].instr, tbl[i].fmt, 4'(i));
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), tbl[i].exp, 4'(i), tbl[i].ill);
      end

      // S then B on consecutive cycles
      @(negedge clk);
      drv(32'hFE112E23, 3'd1, 4'd1);
      @(posedge clk);
      #1 drv(32'hFE000EE3, 3'd2, 4'd2);
      @(negedge clk);
      chk_out("b2b_s", 64'hFFFFFFFF_FFFFFFFC, 4'd1, 1'b0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk_out("b2b_b", 64'hFFFFFFFF_FFFFFFFC, 4'd2, 1'b0);

      // Backpressure: two entries fill, third is held, then drain in order
      @(negedge clk);
      out_ready = 1'b0;
      drv(32'h00100013, 3'd0, 4'd1);
      @(posedge clk);
      #1 drv(32'h00200013, 3'd0, 4'd2);
      @(negedge clk);
      chk_out("bp_one", 64'd1, 4'd1, 1'b0);
      chk_ready("bp_one", 1'b1);
      @(posedge clk);
      #1 drv(32'h00300013, 3'd0, 4'd3);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_out($sformatf("bp_hold%0d", k), 64'd1, 4'd1, 1'b0);
         chk_ready($sformatf("bp_full%0d", k), 1'b0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk_out("bp_drain2", 64'd2, 4'd2, 1'b0);
      chk_ready("bp_drain2", 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk_out("bp_drain3", 64'd3, 4'd3, 1'b0);
      @(negedge clk);
      chk("bp_empty", 64'({ov32, ov64}), 64'd0);

      // Asynchronous reset with the FIFO full
      out_ready = 1'b0;
      drv(32'h00500013, 3'd0, 4'd5);
      @(posedge clk);
      #1 drv(32'h00600013, 3'd0, 4'd6);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk_out("rst_full", 64'd5, 4'd5, 1'b0);
      chk_ready("rst_full", 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_zero("rst_mid");
      chk_ready("rst_mid", 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1 chk_ready("rst_rel", 1'b1);
      chk_zero("rst_rel");
      repeat (2) @(negedge clk);
      chk("rst_nostale", 64'({ov32, ov64}), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
